// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO pair.
// Latency: start to done is WIDTH+2 cycles for every op and operand.
// Backpressure: stall = busy & (start | mf_req | mthi | mtlo); requests while busy are ignored.
//
// Ports: clk, reset (sync, active-high), start/op/a/b launch, mthi/mtlo/wd direct
// HI/LO writes, mf_req (MFHI/MFLO in EX), busy/stall/done status, hi/lo registers.
// Optional macro MULDIV_SIGNED_EN: op[0] selects signed MULT/DIV; undefined means
// all ops are unsigned and the abs/negate logic is absent.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wd,
    input  logic             mf_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;    // P (multiply) or R (divide)
    logic [WIDTH-1:0] acc_lo;    // M (multiply) or Q (divide)
    logic [WIDTH-1:0] operand;   // multiplicand or divisor
    logic             is_div;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             done_r;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
    logic neg_main;   // negate product (mult) or quotient (div)
    logic neg_rem;    // remainder follows the dividend sign
    logic sgn_op;
    logic neg_main_in, neg_rem_in;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign sgn_op = op[0];
    assign a_abs  = (sgn_op & a[WIDTH-1]) ? -a : a;
    assign b_abs  = (sgn_op & b[WIDTH-1]) ? -b : b;
    // A zero divisor must leave the all-ones quotient untouched; the remainder
    // negation then restores the dividend exactly as presented.
    assign neg_main_in = sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]) & (op[1] ? (|b) : 1'b1);
    assign neg_rem_in  = sgn_op & a[WIDTH-1];

    assign prod_fix = neg_main ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign q_fix    = neg_main ? -acc_lo : acc_lo;
    assign r_fix    = neg_rem  ? -acc_hi : acc_hi;
    assign res_hi   = is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo   = is_div ? q_fix : prod_fix[WIDTH-1:0];
`else
    // op[0] carries no meaning when every operation is unsigned.
    logic unused_op0;
    assign unused_op0 = op[0];
    assign a_abs  = a;
    assign b_abs  = b;
    assign res_hi = acc_hi;
    assign res_lo = acc_lo;
`endif

    // Shared add/subtract step. Divide subtracts the divisor from the shifted
    // remainder; carry-out high means no borrow. Multiply adds with carry kept.
    logic [WIDTH:0]   rs, add_x, add_y, p_new;
    logic [WIDTH+1:0] sum;

    assign rs    = {acc_hi, acc_lo[WIDTH-1]};
    assign add_x = is_div ? rs : {1'b0, acc_hi};
    assign add_y = {1'b0, operand} ^ {(WIDTH+1){is_div}};
    assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, is_div};
    assign p_new = acc_lo[0] ? sum[WIDTH:0] : {1'b0, acc_hi};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (cnt == CNT_LAST) state_nx = SIGN;
            SIGN:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nx;
            done_r <= (state == SIGN);
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div  <= op[1];
                        acc_hi  <= '0;
                        acc_lo  <= op[1] ? a_abs : b_abs;
                        operand <= op[1] ? b_abs : a_abs;
                        cnt     <= '0;
`ifdef MULDIV_SIGNED_EN
                        neg_main <= neg_main_in;
                        neg_rem  <= neg_rem_in;
`endif
                    end else begin
                        if (mthi) hi_r <= wd;
                        if (mtlo) lo_r <= wd;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        acc_hi <= sum[WIDTH+1] ? sum[WIDTH-1:0] : rs[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], sum[WIDTH+1]};
                    end else begin
                        acc_hi <= p_new[WIDTH:1];
                        acc_lo <= {p_new[0], acc_lo[WIDTH-1:1]};
                    end
                end
                SIGN: begin
                    hi_r <= res_hi;
                    lo_r <= res_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign stall = busy & (start | mf_req | mthi | mtlo);
    assign done  = done_r;
    assign hi    = hi_r;
    assign lo    = lo_r;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed test of muldiv_seq at WIDTH=32.
// Latency: checks start-to-done of 34 cycles and 33 busy cycles.
// Backpressure: checks stall while busy and that busy-time requests are ignored.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        reset, start, mthi, mtlo, mf_req;
    logic [1:0]  op;
    logic [31:0] a, b, wd;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    int lat, bc, seen;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wd(wd), .mf_req(mf_req),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Continue counting cycles (lat) until done, bounded.
    task automatic wait_done;
        while (!done && lat < 60) begin
            if (busy) bc++;
            tick;
            lat++;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
        op = o; a = av; b = bv; start = 1'b1;
        tick;
        start = 1'b0;
        lat = 1; bc = 0;
        wait_done;
        check({tag, "_latency"}, 64'(lat), 64'd34);
        check({tag, "_busy_cycles"}, 64'(bc), 64'd33);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; mf_req = 1'b0;
        op = 2'b00; a = '0; b = '0; wd = '0;
        tick; tick;
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);

        // MTHI then MFHI in IDLE
        mthi = 1'b1; wd = 32'h1234_5678;
        tick;
        mthi = 1'b0; mf_req = 1'b1;
        #1;
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        check("mf_idle_stall", 64'(stall), 64'd0);
        mf_req = 1'b0;

        // MTHI and MTLO in the same cycle
        mthi = 1'b1; mtlo = 1'b1; wd = 32'h0BAD_F00D;
        tick;
        mthi = 1'b0; mtlo = 1'b0;
        check("mthilo_hi", 64'(hi), 64'h0BAD_F00D);
        check("mthilo_lo", 64'(lo), 64'h0BAD_F00D);

        // start and mtlo together: mtlo is discarded
        op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1; mtlo = 1'b1; wd = 32'hDEAD_BEEF;
        #1;
        check("start_idle_stall", 64'(stall), 64'd0);
        tick;
        start = 1'b0; mtlo = 1'b0;
        lat = 1; bc = 0;
        check("start_mtlo_lo", 64'(lo), 64'h0BAD_F00D);
        check("start_mtlo_busy", 64'(busy), 64'd1);
        wait_done;
        check("start_mtlo_lat", 64'(lat), 64'd34);
        check("start_mtlo_res", 64'(lo), 64'd6);

        // Back-to-back ops; each start lands in the previous done cycle
        run_op(2'b00, 32'd7, 32'd6, 32'h0, 32'h0000_002A, "multu_7x6");
`ifdef MULDIV_SIGNED_EN
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2");
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf");
`else
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, "mult_m3x5");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, "div_m7d2");
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, "div_ovf");
`endif
        run_op(2'b10, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, "divu_by0");
        run_op(2'b11, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, "div_m8_by0");
        run_op(2'b10, 32'd1000, 32'd7, 32'd6, 32'd142, "divu_1000d7");
        tick;

        // Requests during CALC: stall high, second start ignored
        op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
        tick;
        start = 1'b0; lat = 1; bc = 0;
        tick; tick; tick; lat += 3;
        check("calc_no_req_stall", 64'(stall), 64'd0);
        op = 2'b10; a = 32'd1; b = 32'd1; start = 1'b1; mf_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("calc_req_stall", 64'(stall), 64'd1);
            tick; lat++;
        end
        start = 1'b0; mf_req = 1'b0;
        mthi = 1'b1; wd = 32'hFFFF_0000;
        #1;
        check("calc_mthi_stall", 64'(stall), 64'd1);
        tick; lat++;
        mthi = 1'b0;
        wait_done;
        check("calc_req_lat", 64'(lat), 64'd34);
        check("calc_req_hi", 64'(hi), 64'd0);
        check("calc_req_lo", 64'(lo), 64'd81);
        tick;
        check("done_pulse_once", 64'(done), 64'd0);
        check("no_queued_start", 64'(busy), 64'd0);

        // Reset in the middle of a MULTU
        op = 2'b00; a = 32'd5; b = 32'd5; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            tick;
        end
        check("midrst_no_done", 64'(seen), 64'd0);
        run_op(2'b00, 32'd12, 32'd12, 32'h0, 32'd144, "post_rst_multu");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
